// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register: load a word, shift it out one bit per clock.
// Optional PISO_LSB_FIRST_EN sends LSB first instead of MSB first.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (wins over load)
//   load   parallel load strobe (wins over shift)
//   d      parallel word, sampled when load=1
//   q      serial out: MSB of sreg (LSB with PISO_LSB_FIRST_EN)
//   busy   high while q carries a valid data bit (cnt != 0)
module piso_shift_register #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             q,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] shifted;

`ifdef PISO_LSB_FIRST_EN
  assign shifted = {FILL, sreg[WIDTH-1:1]};
  assign q       = sreg[0];
`else
  assign shifted = {sreg[WIDTH-2:0], FILL};
  assign q       = sreg[WIDTH-1];
`endif

  assign busy = (cnt != '0);

  always_comb begin
    sreg_nxt = sreg;
    cnt_nxt  = cnt;
    if (reset) begin
      sreg_nxt = '0;
      cnt_nxt  = '0;
    end else if (load) begin
      sreg_nxt = d;
      cnt_nxt  = FULL;
    end else begin
      // shifting never stops; cnt saturates at zero
      sreg_nxt = shifted;
      if (cnt != '0)
        cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    sreg <= sreg_nxt;
    cnt  <= cnt_nxt;
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboarded bench for piso_shift_register (WIDTH=4, FILL=0).
// Expected q/busy pairs are queued at drive time and popped after each edge.
module tb_piso_shift_register;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] d;
  logic         q;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] sb[$];

  // independent reference: last loaded word and edges since its load
  logic [W-1:0] mw;
  int           mk;

  piso_shift_register #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (d),
    .q     (q),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic l,
                      input logic [W-1:0] dv, input logic eq,
                      input logic eb);
    logic [1:0] e;
    reset = r;
    load  = l;
    d     = dv;
    sb.push_back({eq, eb});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, {31'd0, q}, {31'd0, e[1]});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e[0]});
    end
  endtask

  function automatic logic mbit(input logic [W-1:0] w, input int k);
`ifdef PISO_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  task automatic mstep(input string tag, input logic r, input logic l,
                       input logic [W-1:0] dv);
    logic eq;
    if (r) begin
      mw = '0;
      mk = W;
    end else if (l) begin
      mw = dv;
      mk = 0;
    end else if (mk < W) begin
      mk++;
    end
    eq = (mk < W) ? mbit(mw, mk) : 1'b0;
    step(tag, r, l, dv, eq, mk < W);
    chk({tag, "_x"}, {31'd0, $isunknown({q, busy})}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] dv;
    reset = 1'b1;
    load  = 1'b1;
    d     = 4'hF;
    #1;

`ifndef PISO_LSB_FIRST_EN
    step("rst0", 1, 1, 4'hF, 0, 0);
    step("rst1", 1, 1, 4'hF, 0, 0);

    step("msb_ld", 0, 1, 4'b1011, 1, 1);
    step("msb_s1", 0, 0, 4'hF, 0, 1);
    step("msb_s2", 0, 0, 4'h0, 1, 1);
    step("msb_s3", 0, 0, 4'hF, 1, 1);
    step("msb_s4", 0, 0, 4'h0, 0, 0);
    step("msb_s5", 0, 0, 4'hF, 0, 0);

    step("rl_ld0", 0, 1, 4'b1100, 1, 1);
    step("rl_s1", 0, 0, 4'h0, 1, 1);
    step("rl_s2", 0, 0, 4'h0, 0, 1);
    step("rl_ld1", 0, 1, 4'b0011, 0, 1);
    step("rl_s3", 0, 0, 4'h0, 0, 1);
    step("rl_s4", 0, 0, 4'h0, 1, 1);
    step("rl_s5", 0, 0, 4'h0, 1, 1);
    step("rl_s6", 0, 0, 4'h0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      dv = i[0] ? 4'b0111 : 4'b1000;
      step("cont", 0, 1, dv, ~i[0], 1);
    end

    step("rm_ld", 0, 1, 4'b1111, 1, 1);
    step("rm_s1", 0, 0, 4'h0, 1, 1);
    step("rm_rst", 1, 0, 4'h0, 0, 0);
    step("rm_s2", 0, 0, 4'hF, 0, 0);
    step("rm_s3", 0, 0, 4'hF, 0, 0);
`endif

    // free-running: load toggles each cycle, d inverts every 15 time
    // units, reset pulses near t=15 and t=90
    mstep("fr_rst", 1, 0, 4'h0);
    dv = 4'b1010;
    for (int c = 0; c < 40; c++) begin
      if (((c * 10) / 15) != (((c - 1) * 10) / 15))
        dv = ~dv;
      mstep("fr", (c == 1) || (c == 9), c[0], dv);
    end
    for (int c = 0; c < 12; c++) begin
      dv = 4'($urandom_range(0, 15));
      mstep("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            dv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in/serial-out shift register. Captures a WIDTH-bit word on a load strobe, then shifts it out one bit per clock on a single serial output, MSB first.
- Sits between a parallel data source and a one-wire serial sink, such as a serializer front end or an SPI-style transmitter datapath.
- Provides a busy flag so the sink can tell valid data bits from fill bits.

Parameters:
- WIDTH, 4, parallel word width in bits (≥2).
- FILL, 1'b0, bit value shifted into the vacated end on every shift.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  parallel load strobe, sampled at clk rising edge.
- d  input  WIDTH  parallel data word, sampled when load=1.
- q  output  1  serial data out = current MSB of the shift register (LSB when PISO_LSB_FIRST_EN is defined).
- busy  output  1  high while q carries a valid, not-yet-exhausted data bit.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All ports are named as the codebase does: clk, reset.
- State:
  - sreg[WIDTH-1:0].
  - cnt, width clog2(WIDTH+1), holding the number of valid bits remaining.
  - q and busy are combinational decodes of these registers; there are no additional output flops.
- Priority at each rising edge: reset > load > shift.
- Reset (reset=1): sreg<=0, cnt<=0. On the next cycle q=0 and busy=0. Reset overrides load. Reset mid-shift aborts the word immediately.
- Load (reset=0, load=1):
  - sreg<=d, cnt<=WIDTH.
  - Next cycle: q=d[WIDTH-1], busy=1.
  - A load while busy discards the remaining bits of the old word and restarts with the new word. There is no handshake or back-pressure.
- Shift (reset=0, load=0):
  - sreg<={sreg[WIDTH-2:0],FILL}.
  - cnt<=cnt-1 if cnt>0, else cnt holds at 0 (saturates).
  - Shifting continues while idle, so q=FILL once the word is exhausted.
- Latency: bit d[WIDTH-1-i] appears on q during the cycle after the i-th edge following the load edge (i=0..WIDTH-1).
  - At i=WIDTH, q=FILL and busy=0.
- busy = (cnt!=0).
  - Rises on the cycle after a load edge.
  - Falls on the cycle after the edge that shifts out the last data bit.
- load held high for consecutive cycles: sreg reloads every edge, and q tracks the MSB of the d value sampled at each edge. cnt stays at WIDTH.
- d is ignored when load=0.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: PISO_LSB_FIRST_EN.
- Defined:
  - q=sreg[0].
  - Shift is sreg<={FILL,sreg[WIDTH-1:1]}.
  - The word leaves LSB first; d[0] appears on the cycle after load.
  - busy, cnt and priority rules are unchanged.
- Undefined (default): MSB-first, as described in Behaviour.

Test Plan:
- Reset: reset=1 for 2 edges with load=1, d=4'hF -> q=0, busy=0 after the first reset edge, and reset wins over load.
- MSB-first serialization: load=1 with d=4'b1011 for one edge, then load=0 -> q sequence 1,0,1,1,0,0 on successive cycles; busy=1,1,1,1,0,0.
- Reload mid-word: load 4'b1100, shift 2 edges (q=1,1,0), then load 4'b0011 -> q restarts at 0,0,1,1,0 and busy stays high throughout.
- Continuous load: load=1 while d alternates 4'b1000/4'b0111 each edge -> q alternates 1/0 and busy stays 1.
- Reset mid-shift: load 4'b1111, shift 1 edge, then reset=1 -> next cycle q=0, busy=0; after reset deasserts with load=0, q stays 0.
- Free-running stimulus: clock period 10, load toggling every 10, d inverted every 15, and reset pulses at 15 and 90 -> no X on q or busy after the first reset edge, and q equals d[3] on the cycle after each load edge.
